// File: rtl/mpadder_seq_if.sv
// Command/datapath control bundle for the Montgomery sequencer.
// The master side is the command host plus the adder's status bits; the slave is the sequencer.
interface mpadder_seq_if #(
    parameter int NBITS = 512
);
    logic             start;
    logic [NBITS-1:0] in_b;
    logic             a_lsb;
    logic             c_zero;
    logic             sub_done;
    logic [1:0]       op_sel;
    logic             enable_c;
    logic             shift_c;
    logic             subtract;
    logic [3:0]       chunk;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, in_b, a_lsb, c_zero, sub_done,
        input  op_sel, enable_c, shift_c, subtract, chunk, busy, done, err
    );

    modport slave (
        input  start, in_b, a_lsb, c_zero, sub_done,
        output op_sel, enable_c, shift_c, subtract, chunk, busy, done, err
    );
endinterface

// File: rtl/mpadder_seq.sv
// Sequencer for the carry-save Montgomery datapath: radix-2 loop, chunked carry
// resolve, then repeated conditional-subtract passes with a pass limit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; outputs at rest, chunk frozen (8)
//   S_ADD   | one Montgomery add: op_sel = {q, b_i}, load 3:2 sum
//   S_SHIFT | load shifted sum, advance b and the iteration counter
//   S_RES   | carry resolve, chunk 0..NCHUNK-1 once
//   S_SUB   | conditional subtract passes, chunk 0..NCHUNK-1 per pass
//   S_DONE  | one-cycle completion pulse
module mpadder_seq #(
    parameter int NBITS   = 512,
    parameter int NCHUNK  = 5,
    parameter int MAX_SUB = 4
) (
    input  logic         clk,
    input  logic         resetn,
    mpadder_seq_if.slave bus
);

    localparam int IW = $clog2(NBITS) + 1;
    localparam int PW = $clog2(MAX_SUB + 1);

    localparam logic [IW-1:0] LAST_ITER  = IW'(NBITS - 1);
    localparam logic [3:0]    LAST_CHUNK = 4'(NCHUNK - 1);
    localparam logic [PW-1:0] PASS_LIMIT = PW'(MAX_SUB);
    localparam logic [3:0]    CHUNK_HOLD = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_RES,
        S_SUB,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [3:0]       chunk_q, chunk_d;
    logic [PW-1:0]    pass_q, pass_d;
    logic             err_q, err_d;

    logic [PW-1:0]    pass_inc;
    logic             last_chunk;
    logic             b_i;
    logic             q_bit;

    assign pass_inc   = pass_q + PW'(1);
    assign last_chunk = (chunk_q == LAST_CHUNK);
    assign b_i        = b_q[0];
    assign q_bit      = bus.c_zero ^ (b_i & bus.a_lsb);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            iter_q  <= '0;
            chunk_q <= '0;
            pass_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            iter_q  <= iter_d;
            chunk_q <= chunk_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        iter_d  = iter_q;
        chunk_d = chunk_q;
        pass_d  = pass_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    b_d     = bus.in_b;
                    iter_d  = '0;
                    chunk_d = '0;
                    pass_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                b_d    = b_q >> 1;
                iter_d = iter_q + IW'(1);
                if (iter_q == LAST_ITER) begin
                    chunk_d = '0;
                    state_d = S_RES;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_RES: begin
                if (last_chunk) begin
                    chunk_d = '0;
                    pass_d  = '0;
                    state_d = S_SUB;
                end else begin
                    chunk_d = chunk_q + 4'd1;
                end
            end
            S_SUB: begin
                if (last_chunk) begin
                    chunk_d = '0;
                    if (bus.sub_done) begin
                        state_d = S_DONE;
                    end else begin
                        // A pass that still needs another subtract counts toward the limit.
                        pass_d = pass_inc;
                        if (pass_inc == PASS_LIMIT) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end else begin
                    chunk_d = chunk_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.op_sel   = 2'd0;
        bus.enable_c = 1'b0;
        bus.shift_c  = 1'b0;
        bus.subtract = 1'b0;
        bus.chunk    = CHUNK_HOLD;
        bus.busy     = (state_q != S_IDLE);
        bus.done     = 1'b0;
        bus.err      = err_q;
        case (state_q)
            S_ADD: begin
                bus.op_sel   = {q_bit, b_i};
                bus.enable_c = 1'b1;
            end
            S_SHIFT: begin
                bus.shift_c = 1'b1;
            end
            S_RES: begin
                bus.chunk = chunk_q;
            end
            S_SUB: begin
                bus.subtract = 1'b1;
                bus.op_sel   = 2'd2;
                bus.chunk    = chunk_q;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
